// File: rtl/prog_sequencer.sv
// ============================================================================
// Module   : prog_sequencer
// Purpose  : Runs a batch of programs on the core via its START/DONE handshake,
//            timing each program and aborting the batch on timeout.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_sequencer #(
  parameter int NUM_PROGS      = 2,
  parameter int START_CYCLES   = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int PID_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             GO,
  input  logic             DONE,
  output logic             START,
  output logic [PID_W-1:0] PROG_ID,
  output logic             BUSY,
  output logic             RESULT_VALID,
  output logic [CNT_W-1:0] CYCLE_COUNT,
  output logic             ALL_DONE,
  output logic             TIMEOUT_ERR
);

  localparam int PH_MAX = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0]  START_LAST  = PH_W'(START_CYCLES - 1);
  localparam logic [PH_W-1:0]  GAP_LAST    = PH_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PID_W-1:0] LAST_PID    = PID_W'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ASSERT  = 3'd1,
    S_HOLDOFF = 3'd2,
    S_WAIT    = 3'd3,
    S_REPORT  = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t           state_q;
  logic [PH_W-1:0]  phase_q;
  logic [CNT_W-1:0] cnt_q;
  logic             abort_q;
  logic             start_q;
  logic [PID_W-1:0] pid_q;
  logic             busy_q;
  logic             rv_q;
  logic [CNT_W-1:0] count_q;
  logic             all_done_q;
  logic             terr_q;

  logic [CNT_W-1:0] cnt_d;

  // Saturating increment so a stuck core never wraps the count back to small values
  assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      start_q    <= 1'b0;
      pid_q      <= '0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      count_q    <= '0;
      all_done_q <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (GO) begin
            state_q <= S_ASSERT;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            pid_q   <= '0;
            terr_q  <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= CNT_W'(1);
            phase_q <= '0;
          end
        end
        S_ASSERT: begin
          cnt_q <= cnt_d;
          if (phase_q == START_LAST) begin
            phase_q <= '0;
            start_q <= 1'b0;
            state_q <= (GAP_CYCLES > 0) ? S_HOLDOFF : S_WAIT;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        S_HOLDOFF: begin
          // DONE deliberately not looked at: it may still be high from the last program
          cnt_q <= cnt_d;
          if (phase_q == GAP_LAST) begin
            phase_q <= '0;
            state_q <= S_WAIT;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        S_WAIT: begin
          if (DONE) begin
            count_q <= cnt_q;
            rv_q    <= 1'b1;
            abort_q <= 1'b0;
            state_q <= S_REPORT;
          end else if (cnt_q >= TIMEOUT_CNT) begin
            count_q <= TIMEOUT_CNT;
            rv_q    <= 1'b1;
            terr_q  <= 1'b1;
            abort_q <= 1'b1;
            state_q <= S_REPORT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_REPORT: begin
          rv_q <= 1'b0;
          if (abort_q || (pid_q == LAST_PID)) begin
            all_done_q <= 1'b1;
            state_q    <= S_FINISH;
          end else begin
            pid_q   <= pid_q + PID_W'(1);
            start_q <= 1'b1;
            cnt_q   <= CNT_W'(1);
            phase_q <= '0;
            state_q <= S_ASSERT;
          end
        end
        S_FINISH: begin
          all_done_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          start_q    <= 1'b0;
          busy_q     <= 1'b0;
          rv_q       <= 1'b0;
          all_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign START        = start_q;
  assign PROG_ID      = pid_q;
  assign BUSY         = busy_q;
  assign RESULT_VALID = rv_q;
  assign CYCLE_COUNT  = count_q;
  assign ALL_DONE     = all_done_q;
  assign TIMEOUT_ERR  = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
// ============================================================================
// Module   : tb_prog_sequencer
// Purpose  : Directed bench for prog_sequencer over three parameter sets, with
//            a queue scoreboard checking every RESULT_VALID report.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_sequencer;

  typedef struct {
    int pid;
    int cnt;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int nad_a = 0;
  int nad_b = 0;
  int nad_c = 0;

  // DUT A: defaults
  logic go_a = 1'b0, done_a = 1'b0;
  logic start_a, busy_a, rv_a, ad_a, terr_a;
  logic [0:0]  pid_a;
  logic [15:0] cnt_a;

  prog_sequencer u_a (
    .CLK(CLK), .RESET(RESET), .GO(go_a), .DONE(done_a),
    .START(start_a), .PROG_ID(pid_a), .BUSY(busy_a), .RESULT_VALID(rv_a),
    .CYCLE_COUNT(cnt_a), .ALL_DONE(ad_a), .TIMEOUT_ERR(terr_a)
  );

  // DUT B: short timeout
  logic go_b = 1'b0, done_b = 1'b0;
  logic start_b, busy_b, rv_b, ad_b, terr_b;
  logic [0:0]  pid_b;
  logic [15:0] cnt_b;

  prog_sequencer #(.TIMEOUT_CYCLES(20)) u_b (
    .CLK(CLK), .RESET(RESET), .GO(go_b), .DONE(done_b),
    .START(start_b), .PROG_ID(pid_b), .BUSY(busy_b), .RESULT_VALID(rv_b),
    .CYCLE_COUNT(cnt_b), .ALL_DONE(ad_b), .TIMEOUT_ERR(terr_b)
  );

  // DUT C: three programs, one-cycle START, no hold-off
  logic go_c = 1'b0, done_c = 1'b0;
  logic start_c, busy_c, rv_c, ad_c, terr_c;
  logic [1:0]  pid_c;
  logic [15:0] cnt_c;

  prog_sequencer #(.NUM_PROGS(3), .START_CYCLES(1), .GAP_CYCLES(0)) u_c (
    .CLK(CLK), .RESET(RESET), .GO(go_c), .DONE(done_c),
    .START(start_c), .PROG_ID(pid_c), .BUSY(busy_c), .RESULT_VALID(rv_c),
    .CYCLE_COUNT(cnt_c), .ALL_DONE(ad_c), .TIMEOUT_ERR(terr_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  function automatic exp_t mk(input int p, input int c);
    exp_t e;
    e.pid = p;
    e.cnt = c;
    return e;
  endfunction

  // Scoreboard: every report must match the next expected entry
  always @(negedge CLK) begin
    exp_t e;
    if (rv_a === 1'b1) begin
      if (qa.size() == 0) check("a_unexpected_rv", 32'(rv_a), 32'd0);
      else begin
        e = qa.pop_front();
        check("a_prog_id", 32'(pid_a), 32'(e.pid));
        check("a_cycle_count", 32'(cnt_a), 32'(e.cnt));
      end
    end
    if (rv_b === 1'b1) begin
      if (qb.size() == 0) check("b_unexpected_rv", 32'(rv_b), 32'd0);
      else begin
        e = qb.pop_front();
        check("b_prog_id", 32'(pid_b), 32'(e.pid));
        check("b_cycle_count", 32'(cnt_b), 32'(e.cnt));
      end
    end
    if (rv_c === 1'b1) begin
      if (qc.size() == 0) check("c_unexpected_rv", 32'(rv_c), 32'd0);
      else begin
        e = qc.pop_front();
        check("c_prog_id", 32'(pid_c), 32'(e.pid));
        check("c_cycle_count", 32'(cnt_c), 32'(e.cnt));
      end
    end
    if (ad_a === 1'b1) nad_a++;
    if (ad_b === 1'b1) nad_b++;
    if (ad_c === 1'b1) nad_c++;
  end

  initial begin
    // Reset
    RESET = 1'b1;
    tick();
    tick();
    check("a_reset_outs", 32'({start_a, pid_a, busy_a, rv_a, cnt_a, ad_a, terr_a}), 32'd0);
    check("b_reset_outs", 32'({start_b, pid_b, busy_b, rv_b, cnt_b, ad_b, terr_b}), 32'd0);
    check("c_reset_outs", 32'({start_c, pid_c, busy_c, rv_c, cnt_c, ad_c, terr_c}), 32'd0);
    RESET = 1'b0;
    tick();

    // Basic timing, DONE at cycle 10 then DONE held for program 1
    go_a = 1'b1; cyc = 0;
    qa.push_back(mk(0, 10));
    tick();
    go_a = 1'b0;
    check("a_start_c1", 32'(start_a), 32'd1);
    check("a_busy_c1", 32'(busy_a), 32'd1);
    tick();
    check("a_start_c2", 32'(start_a), 32'd1);
    tick();
    check("a_start_c3", 32'(start_a), 32'd0);
    run_to(10);
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    check("a_rv_c11", 32'(rv_a), 32'd1);
    run_to(12);
    check("a_start_c12", 32'(start_a), 32'd1);
    check("a_pid_c12", 32'(pid_a), 32'd1);
    tick();
    check("a_start_c13", 32'(start_a), 32'd1);
    done_a = 1'b1;
    qa.push_back(mk(1, 5));
    run_to(18);
    check("a_alldone_c18", 32'(ad_a), 32'd1);
    tick();
    check("a_busy_c19", 32'(busy_a), 32'd0);
    check("a_alldone_c19", 32'(ad_a), 32'd0);
    check("a_pid_hold", 32'(pid_a), 32'd1);

    // DONE held high throughout: stale DONE ignored during START and hold-off
    go_a = 1'b1; cyc = 0;
    qa.push_back(mk(0, 5));
    qa.push_back(mk(1, 5));
    tick();
    go_a = 1'b0;
    run_to(6);
    check("a_held_rv0", 32'(rv_a), 32'd1);
    run_to(12);
    check("a_held_rv1", 32'(rv_a), 32'd1);
    tick();
    check("a_held_alldone", 32'(ad_a), 32'd1);
    tick();
    check("a_held_busy_fall", 32'(busy_a), 32'd0);
    done_a = 1'b0;

    // Reset during WAIT of program 1
    go_a = 1'b1; cyc = 0;
    qa.push_back(mk(0, 7));
    tick();
    go_a = 1'b0;
    run_to(7);
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    run_to(15);
    check("a_prerst_busy", 32'(busy_a), 32'd1);
    check("a_prerst_pid", 32'(pid_a), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("a_rst_outs", 32'({start_a, busy_a, pid_a, rv_a, ad_a}), 32'd0);
    repeat (5) tick();
    done_a = 1'b1;
    go_a = 1'b1; cyc = 0;
    qa.push_back(mk(0, 5));
    qa.push_back(mk(1, 5));
    tick();
    go_a = 1'b0;
    run_to(14);
    check("a_rerun_busy_fall", 32'(busy_a), 32'd0);
    done_a = 1'b0;

    // Timeout aborts the batch
    go_b = 1'b1; cyc = 0;
    qb.push_back(mk(0, 20));
    tick();
    go_b = 1'b0;
    run_to(21);
    check("b_to_rv", 32'(rv_b), 32'd1);
    check("b_to_terr", 32'(terr_b), 32'd1);
    tick();
    check("b_to_alldone", 32'(ad_b), 32'd1);
    check("b_to_no_start", 32'(start_b), 32'd0);
    tick();
    check("b_to_busy_fall", 32'(busy_b), 32'd0);
    check("b_to_terr_sticky", 32'(terr_b), 32'd1);
    check("b_to_no_start2", 32'(start_b), 32'd0);

    // DONE arriving exactly at the timeout count wins
    go_b = 1'b1; cyc = 0;
    tick();
    go_b = 1'b0;
    check("b_terr_cleared", 32'(terr_b), 32'd0);
    qb.push_back(mk(0, 20));
    run_to(20);
    done_b = 1'b1;
    tick();
    check("b_edge_rv", 32'(rv_b), 32'd1);
    check("b_edge_terr", 32'(terr_b), 32'd0);
    qb.push_back(mk(1, 5));
    run_to(28);
    check("b_edge_alldone", 32'(ad_b), 32'd1);
    tick();
    check("b_edge_busy_fall", 32'(busy_b), 32'd0);
    check("b_edge_terr_end", 32'(terr_b), 32'd0);
    done_b = 1'b0;

    // Three programs, no hold-off, GO chattering during the run
    done_c = 1'b1;
    go_c = 1'b1; cyc = 0;
    qc.push_back(mk(0, 2));
    qc.push_back(mk(1, 2));
    qc.push_back(mk(2, 2));
    tick();
    check("c_start_c1", 32'(start_c), 32'd1);
    check("c_busy_c1", 32'(busy_c), 32'd1);
    while (cyc < 9) begin
      go_c = (cyc % 2 == 0);
      tick();
      if (cyc == 2) check("c_start_c2", 32'(start_c), 32'd0);
      if (cyc == 4) check("c_pid_c4", 32'(pid_c), 32'd1);
    end
    go_c = 1'b0;
    run_to(10);
    check("c_alldone", 32'(ad_c), 32'd1);
    tick();
    check("c_busy_fall", 32'(busy_c), 32'd0);
    repeat (3) tick();
    check("c_stays_idle", 32'(busy_c), 32'd0);
    done_c = 1'b0;
    repeat (2) tick();

    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);
    check("c_queue_drained", 32'(qc.size()), 32'd0);
    check("a_alldone_count", 32'(nad_a), 32'd3);
    check("b_alldone_count", 32'(nad_b), 32'd2);
    check("c_alldone_count", 32'(nad_c), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
